// File: rtl/core_ex_lsu_ctrl_pkg.sv
// Shared widths, instruction bit positions, cause codes and sequencer state
// encoding for the EX-stage load/store controller.
package core_ex_lsu_ctrl_pkg;

    localparam int CORE_XLEN            = 32;
    localparam int CORE_LSU_INST_WIDTH  = 4;
    localparam int CORE_LSU_WMASK_WIDTH = 4;

    localparam int CORE_LSU_INST_B  = 0;
    localparam int CORE_LSU_INST_H  = 1;
    localparam int CORE_LSU_INST_W  = 2;
    localparam int CORE_LSU_INST_LU = 3;

    localparam logic [1:0] CORE_LSU_CAUSE_NONE = 2'b00;
    localparam logic [1:0] CORE_LSU_CAUSE_LMA  = 2'b01;
    localparam logic [1:0] CORE_LSU_CAUSE_SMA  = 2'b10;
    localparam logic [1:0] CORE_LSU_CAUSE_AF   = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_REQ   = 2'b01,
        LSU_RSP   = 2'b10,
        LSU_DRAIN = 2'b11
    } lsu_state_e;

    // Natural alignment: halfwords on even bytes, words on word boundaries.
    function automatic logic lsu_misaligned(
        input logic [CORE_LSU_INST_WIDTH-1:0] inst,
        input logic [1:0]                     addr_lo
    );
        logic mis;
        mis = 1'b0;
        if (inst[CORE_LSU_INST_W]) begin
            mis = (addr_lo != 2'b00);
        end else if (inst[CORE_LSU_INST_H]) begin
            mis = addr_lo[0];
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/core_ex_lsu_ctrl_align.sv
// Byte-lane alignment datapath: store mask/data lane shifting and
// load data extraction with sign or zero extension.
module core_ex_lsu_align
    import core_ex_lsu_ctrl_pkg::*;
(
    input  logic [CORE_LSU_INST_WIDTH-1:0]  inst,
    input  logic [1:0]                      addr_lo,
    input  logic                            wen,
    input  logic [CORE_XLEN-1:0]            wdata,
    input  logic [CORE_XLEN-1:0]            rdata,
    output logic [CORE_LSU_WMASK_WIDTH-1:0] wmask,
    output logic [CORE_XLEN-1:0]            wdata_sh,
    output logic [CORE_XLEN-1:0]            rdata_al
);

    logic [4:0]                      shamt_s;
    logic [CORE_XLEN-1:0]            rshift_s;
    logic [CORE_LSU_WMASK_WIDTH-1:0] mask_base_s;
    logic                            sext_s;

    // Lane shift by byte offset; size bits select the extract width, no size bit behaves as a word.
    always_comb begin
        shamt_s  = {addr_lo, 3'b000};
        rshift_s = rdata >> shamt_s;
        wdata_sh = wdata << shamt_s;
        sext_s   = ~inst[CORE_LSU_INST_LU];
        if (inst[CORE_LSU_INST_B]) begin
            mask_base_s = 4'b0001;
            rdata_al    = {{(CORE_XLEN-8){sext_s & rshift_s[7]}}, rshift_s[7:0]};
        end else if (inst[CORE_LSU_INST_H]) begin
            mask_base_s = 4'b0011;
            rdata_al    = {{(CORE_XLEN-16){sext_s & rshift_s[15]}}, rshift_s[15:0]};
        end else begin
            mask_base_s = 4'b1111;
            rdata_al    = rshift_s;
        end
        if (wen) begin
            wmask = mask_base_s << addr_lo;
        end else begin
            wmask = 4'b0000;
        end
    end

endmodule

// File: rtl/core_ex_lsu_ctrl.sv
// EX-stage load/store sequencer: alignment check, single outstanding
// memory access with response timeout, and one completion record per request.
module core_ex_lsu_ctrl
    import core_ex_lsu_ctrl_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wen,
    input  logic [CORE_LSU_INST_WIDTH-1:0]  req_lsu_inst,
    input  logic [CORE_XLEN-1:0]            req_addr,
    input  logic [CORE_XLEN-1:0]            req_wdata,
    input  logic [4:0]                      req_rd,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [CORE_XLEN-1:0]            mem_req_addr,
    output logic                            mem_req_wen,
    output logic [CORE_XLEN-1:0]            mem_req_wdata,
    output logic [CORE_LSU_WMASK_WIDTH-1:0] mem_req_wmask,
    input  logic                            mem_rsp_valid,
    input  logic [CORE_XLEN-1:0]            mem_rsp_rdata,
    input  logic                            mem_rsp_err,
    output logic                            cmp_valid,
    output logic                            cmp_rd_wen,
    output logic [4:0]                      cmp_rd,
    output logic [CORE_XLEN-1:0]            cmp_data,
    output logic                            cmp_exc,
    output logic [1:0]                      cmp_cause,
    output logic                            busy
);

    localparam logic [7:0] TO_LIMIT = 8'(RSP_TIMEOUT - 1);

    lsu_state_e                     state_r, state_s;
    logic                           wen_r;
    logic [CORE_LSU_INST_WIDTH-1:0] inst_r;
    logic [CORE_XLEN-1:0]           addr_r;
    logic [CORE_XLEN-1:0]           wdata_r;
    logic [4:0]                     rd_r;
    logic [7:0]                     cnt_r, cnt_s;

    logic                           accept_s;
    logic                           misal_s;
    logic                           expired_s;

    logic                           cmp_valid_r, cmp_valid_s;
    logic                           cmp_rd_wen_r, cmp_rd_wen_s;
    logic [4:0]                     cmp_rd_r, cmp_rd_s;
    logic [CORE_XLEN-1:0]           cmp_data_r, cmp_data_s;
    logic                           cmp_exc_r, cmp_exc_s;
    logic [1:0]                     cmp_cause_r, cmp_cause_s;

    logic [CORE_LSU_WMASK_WIDTH-1:0] wmask_s;
    logic [CORE_XLEN-1:0]            wdata_sh_s;
    logic [CORE_XLEN-1:0]            rdata_al_s;

    core_ex_lsu_align u_align (
        .inst     (inst_r),
        .addr_lo  (addr_r[1:0]),
        .wen      (wen_r),
        .wdata    (wdata_r),
        .rdata    (mem_rsp_rdata),
        .wmask    (wmask_s),
        .wdata_sh (wdata_sh_s),
        .rdata_al (rdata_al_s)
    );

    assign req_ready     = (state_r == LSU_IDLE) & ~flush;
    assign accept_s      = req_valid & req_ready;
    assign misal_s       = lsu_misaligned(req_lsu_inst, req_addr[1:0]);
    assign expired_s     = (cnt_r >= TO_LIMIT);
    assign busy          = (state_r != LSU_IDLE);

    assign mem_req_valid = (state_r == LSU_REQ);
    assign mem_req_addr  = {addr_r[CORE_XLEN-1:2], 2'b00};
    assign mem_req_wen   = wen_r;
    assign mem_req_wdata = wdata_sh_s;
    assign mem_req_wmask = wmask_s;

    assign cmp_valid     = cmp_valid_r;
    assign cmp_rd_wen    = cmp_rd_wen_r;
    assign cmp_rd        = cmp_rd_r;
    assign cmp_data      = cmp_data_r;
    assign cmp_exc       = cmp_exc_r;
    assign cmp_cause     = cmp_cause_r;

    // Next-state, timeout counter and completion record; flush outranks every other input.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        cmp_valid_s  = 1'b0;
        cmp_rd_wen_s = 1'b0;
        cmp_rd_s     = rd_r;
        cmp_data_s   = '0;
        cmp_exc_s    = 1'b0;
        cmp_cause_s  = CORE_LSU_CAUSE_NONE;
        case (state_r)
            LSU_IDLE: begin
                if (accept_s && misal_s) begin
                    cmp_valid_s = 1'b1;
                    cmp_exc_s   = 1'b1;
                    cmp_cause_s = req_wen ? CORE_LSU_CAUSE_SMA : CORE_LSU_CAUSE_LMA;
                    cmp_data_s  = req_addr;
                    cmp_rd_s    = req_rd;
                end else if (accept_s) begin
                    state_s = LSU_REQ;
                end else begin
                    state_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (flush) begin
                    state_s = LSU_IDLE;
                end else if (mem_req_ready) begin
                    state_s = LSU_RSP;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = LSU_REQ;
                end
            end
            LSU_RSP: begin
                if (flush) begin
                    state_s = LSU_DRAIN;
                    cnt_s   = cnt_r + 8'd1;
                end else if (mem_rsp_valid) begin
                    state_s     = LSU_IDLE;
                    cmp_valid_s = 1'b1;
                    if (mem_rsp_err) begin
                        cmp_exc_s   = 1'b1;
                        cmp_cause_s = CORE_LSU_CAUSE_AF;
                        cmp_data_s  = addr_r;
                    end else if (!wen_r) begin
                        cmp_rd_wen_s = 1'b1;
                        cmp_data_s   = rdata_al_s;
                    end else begin
                        cmp_rd_wen_s = 1'b0;
                    end
                end else if (expired_s) begin
                    state_s     = LSU_IDLE;
                    cmp_valid_s = 1'b1;
                    cmp_exc_s   = 1'b1;
                    cmp_cause_s = CORE_LSU_CAUSE_AF;
                    cmp_data_s  = addr_r;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            LSU_DRAIN: begin
                // The bus still owes a beat; swallow it (or give up) silently.
                if (mem_rsp_valid || expired_s) begin
                    state_s = LSU_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = LSU_IDLE;
            end
        endcase
    end

    // State, counter and completion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= LSU_IDLE;
            cnt_r        <= 8'd0;
            cmp_valid_r  <= 1'b0;
            cmp_rd_wen_r <= 1'b0;
            cmp_rd_r     <= 5'd0;
            cmp_data_r   <= '0;
            cmp_exc_r    <= 1'b0;
            cmp_cause_r  <= CORE_LSU_CAUSE_NONE;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            cmp_valid_r  <= cmp_valid_s;
            cmp_rd_wen_r <= cmp_rd_wen_s;
            cmp_rd_r     <= cmp_rd_s;
            cmp_data_r   <= cmp_data_s;
            cmp_exc_r    <= cmp_exc_s;
            cmp_cause_r  <= cmp_cause_s;
        end
    end

    // Request latch, loaded on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_r   <= 1'b0;
            inst_r  <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            rd_r    <= 5'd0;
        end else if (accept_s) begin
            wen_r   <= req_wen;
            inst_r  <= req_lsu_inst;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            rd_r    <= req_rd;
        end else begin
            wen_r   <= wen_r;
            inst_r  <= inst_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            rd_r    <= rd_r;
        end
    end

endmodule

// File: tb/tb_core_ex_lsu_ctrl.sv
// Scenario bench for core_ex_lsu_ctrl: expected completions are queued at
// request time and matched by a monitor when cmp_valid pulses.
module tb_core_ex_lsu_ctrl;
    import core_ex_lsu_ctrl_pkg::*;

    typedef struct packed {
        logic        rd_wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [1:0]  cause;
        logic        chk_data;
    } exp_t;

    localparam logic [3:0] I_B  = 4'b0001;
    localparam logic [3:0] I_H  = 4'b0010;
    localparam logic [3:0] I_W  = 4'b0100;
    localparam logic [3:0] I_LU = 4'b1000;

    logic        clk, rst_n, flush;
    logic        req_valid, req_ready, req_wen;
    logic [3:0]  req_lsu_inst;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic        cmp_valid, cmp_rd_wen, cmp_exc;
    logic [4:0]  cmp_rd;
    logic [31:0] cmp_data;
    logic [1:0]  cmp_cause;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    core_ex_lsu_ctrl #(.RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_lsu_inst(req_lsu_inst), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .cmp_valid(cmp_valid), .cmp_rd_wen(cmp_rd_wen), .cmp_rd(cmp_rd), .cmp_data(cmp_data),
        .cmp_exc(cmp_exc), .cmp_cause(cmp_cause), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic rd_wen, input logic [4:0] rd, input logic [31:0] data,
                                input logic exc, input logic [1:0] cause, input logic chk_data);
        exp_t e;
        e.rd_wen = rd_wen; e.rd = rd; e.data = data; e.exc = exc; e.cause = cause; e.chk_data = chk_data;
        return e;
    endfunction

    // Scoreboard: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && cmp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_cmp: got rd_wen=%0b rd=%0d data=%h exc=%0b cause=%0b, none expected",
                         cmp_rd_wen, cmp_rd, cmp_data, cmp_exc, cmp_cause);
            end else begin
                mon_e = exp_q.pop_front();
                if (cmp_rd_wen !== mon_e.rd_wen || cmp_rd !== mon_e.rd || cmp_exc !== mon_e.exc ||
                    cmp_cause !== mon_e.cause || (mon_e.chk_data && cmp_data !== mon_e.data)) begin
                    bad++;
                    $display("FAIL cmp_record: got rd_wen=%0b rd=%0d data=%h exc=%0b cause=%0b, want rd_wen=%0b rd=%0d data=%h exc=%0b cause=%0b",
                             cmp_rd_wen, cmp_rd, cmp_data, cmp_exc, cmp_cause,
                             mon_e.rd_wen, mon_e.rd, mon_e.data, mon_e.exc, mon_e.cause);
                end
            end
        end
    end

    // Drive a request at the current negedge, handshake after rdy_wait cycles, respond at once.
    task automatic access(input logic wen, input logic [3:0] inst, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic err, input int rdy_wait);
        req_valid = 1'b1; req_wen = wen; req_lsu_inst = inst;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (rdy_wait) @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_err = err;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if (cmp_valid !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: cmp_valid=%0b busy=%0b mem_req_valid=%0b, want 0 0 0", cmp_valid, busy, mem_req_valid);
        end
        total++;
        if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wmask !== 4'h0 || mem_req_wen !== 1'b0) begin
            bad++; $display("FAIL reset_memreq: addr=%h wdata=%h wmask=%b wen=%0b, want all 0", mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen);
        end
        total++;
        if (cmp_data !== 32'h0 || cmp_exc !== 1'b0 || cmp_cause !== 2'b00 || cmp_rd_wen !== 1'b0) begin
            bad++; $display("FAIL reset_cmp: data=%h exc=%0b cause=%0b rd_wen=%0b, want all 0", cmp_data, cmp_exc, cmp_cause, cmp_rd_wen);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: req_ready=%0b want 1", req_ready);
        end
    endtask

    task automatic test_lw;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_lsu_inst = I_W; req_addr = 32'h100; req_rd = 5'd3;
        exp_q.push_back(mk(1'b1, 5'd3, 32'h8899AABB, 1'b0, 2'b00, 1'b1));
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_wmask !== 4'b0000 || mem_req_wen !== 1'b0) begin
            bad++; $display("FAIL lw_req: valid=%0b addr=%h wmask=%b wen=%0b, want 1 00000100 0000 0", mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wen);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL lw_rsp_wait: mem_req_valid=%0b busy=%0b, want 0 1", mem_req_valid, busy);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h8899AABB;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++;
        if (cmp_valid !== 1'b1 || req_ready !== 1'b1) begin
            bad++; $display("FAIL lw_cmp_cycle: cmp_valid=%0b req_ready=%0b, want 1 1", cmp_valid, req_ready);
        end
        @(negedge clk);
        total++;
        if (cmp_valid !== 1'b0) begin
            bad++; $display("FAIL lw_cmp_pulse: cmp_valid=%0b want 0", cmp_valid);
        end
    endtask

    task automatic test_store;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_lsu_inst = I_H; req_addr = 32'h202;
        req_wdata = 32'h0000_1234; req_rd = 5'd0;
        exp_q.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0));
        @(negedge clk);
        req_valid = 1'b0; req_wdata = 32'hDEAD_BEEF;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || mem_req_wmask !== 4'b1100 ||
            mem_req_wdata !== 32'h1234_0000 || mem_req_wen !== 1'b1) begin
            bad++; $display("FAIL sh_req: valid=%0b addr=%h wmask=%b wdata=%h wen=%0b, want 1 00000200 1100 12340000 1",
                            mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wdata, mem_req_wen);
        end
        @(negedge clk);
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_wmask !== 4'b1100 || mem_req_wdata !== 32'h1234_0000) begin
            bad++; $display("FAIL sh_hold: valid=%0b wmask=%b wdata=%h, want 1 1100 12340000", mem_req_valid, mem_req_wmask, mem_req_wdata);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++;
        if (cmp_valid !== 1'b1) begin
            bad++; $display("FAIL sh_cmp_cycle: cmp_valid=%0b want 1", cmp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  insts [4] = '{I_B, I_B | I_LU, I_H, I_H | I_LU};
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rds   [4] = '{32'h8011_2233, 32'h8011_2233, 32'hF00D_1234, 32'hF00D_1234};
        logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F00D, 32'h0000_F00D};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b1, 5'(i + 10), exps[i], 1'b0, 2'b00, 1'b1));
            access(1'b0, insts[i], addrs[i], 32'h0, 5'(i + 10), rds[i], 1'b0, i % 2);
            total++;
            if (req_ready !== 1'b1 || cmp_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_ready_%0d: req_ready=%0b cmp_valid=%0b, want 1 1", i, req_ready, cmp_valid);
            end
        end
        exp_q.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, CORE_LSU_CAUSE_AF, 1'b1));
        exp_q[exp_q.size()-1].data = 32'h300;
        exp_q[exp_q.size()-1].rd   = 5'd7;
        access(1'b0, I_W, 32'h300, 32'h0, 5'd7, 32'h1111_2222, 1'b1, 0);
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_lsu_inst = I_W; req_addr = 32'h101; req_rd = 5'd4;
        exp_q.push_back(mk(1'b0, 5'd4, 32'h101, 1'b1, CORE_LSU_CAUSE_LMA, 1'b1));
        @(negedge clk);
        total++;
        if (mem_req_valid !== 1'b0 || cmp_valid !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL lma_cycle1: mem_req_valid=%0b cmp_valid=%0b req_ready=%0b busy=%0b, want 0 1 1 0",
                            mem_req_valid, cmp_valid, req_ready, busy);
        end
        req_wen = 1'b1; req_lsu_inst = I_H; req_addr = 32'h203; req_rd = 5'd5;
        exp_q.push_back(mk(1'b0, 5'd5, 32'h203, 1'b1, CORE_LSU_CAUSE_SMA, 1'b1));
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0 || cmp_valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL sma_cycle: mem_req_valid=%0b cmp_valid=%0b busy=%0b, want 0 1 0", mem_req_valid, cmp_valid, busy);
        end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_lsu_inst = I_W; req_addr = 32'h400; req_rd = 5'd9;
        exp_q.push_back(mk(1'b0, 5'd9, 32'h400, 1'b1, CORE_LSU_CAUSE_AF, 1'b1));
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cmp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL timeout_early: cmp_valid=%0b busy=%0b, want 0 1", cmp_valid, busy);
        end
        @(negedge clk);
        total++;
        if (cmp_valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_cycle: cmp_valid=%0b busy=%0b, want 1 0", cmp_valid, busy);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_lsu_inst = I_W; req_addr = 32'h500; req_rd = 5'd6;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1; mem_req_ready = 1'b1;
        total++;
        if (req_ready !== 1'b0 || mem_req_valid !== 1'b1) begin
            bad++; $display("FAIL flush_req_pre: req_ready=%0b mem_req_valid=%0b, want 0 1", req_ready, mem_req_valid);
        end
        @(negedge clk);
        flush = 1'b0; mem_req_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || cmp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_req_idle: busy=%0b mem_req_valid=%0b cmp_valid=%0b, want 0 0 0", busy, mem_req_valid, cmp_valid);
        end
        req_valid = 1'b1; req_addr = 32'h504;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL flush_rsp_drain: busy=%0b req_ready=%0b, want 1 0", busy, req_ready);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || cmp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_rsp_done: busy=%0b req_ready=%0b cmp_valid=%0b, want 0 1 0", busy, req_ready, cmp_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_lsu_inst = I_W; req_addr = 32'h600; req_rd = 5'd8;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (cmp_valid !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0 || cmp_exc !== 1'b0 || mem_req_wmask !== 4'h0) begin
            bad++; $display("FAIL rst_mid: cmp_valid=%0b busy=%0b mem_req_valid=%0b cmp_exc=%0b wmask=%b, want all 0",
                            cmp_valid, busy, mem_req_valid, cmp_exc, mem_req_wmask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || cmp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rst_stray_rsp: busy=%0b cmp_valid=%0b req_ready=%0b, want 0 0 1", busy, cmp_valid, req_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_lsu_inst = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_lw();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid();
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL missing_cmp: %0d completions outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_ex_lsu_ctrl.md
# core_ex_lsu_ctrl

Load/store sequencer for the EX-stage LSU. It accepts one memory instruction at a time from EX and checks natural alignment. Aligned accesses go out on a word-addressed valid/ready memory port, and the controller waits for the response with a timeout. It then returns one completion record: aligned load data, store done, or exception. It instantiates the byte-lane alignment datapath and owns all sequencing around it.

## Interface
Parameters:
- RSP_TIMEOUT, 255: cycles in RSP without mem_rsp_valid before an access fault; range 1..255.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline kill
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE with flush low
- req_wen  in  1  1 = store, 0 = load
- req_lsu_inst  in  CORE_LSU_INST_WIDTH  size/unsigned one-hot bits: B, H, W, LU
- req_addr  in  CORE_XLEN  byte address
- req_wdata  in  CORE_XLEN  store data, LSB-justified
- req_rd  in  5  load destination
- mem_req_valid, mem_req_ready  out/in  1  memory request handshake
- mem_req_addr  out  CORE_XLEN  {addr[31:2],2'b00}
- mem_req_wen  out  1  store flag
- mem_req_wdata  out  CORE_XLEN  lane-shifted store data
- mem_req_wmask  out  CORE_LSU_WMASK_WIDTH  byte enables, 0 for loads
- mem_rsp_valid  in  1  response strobe; no ready, always accepted
- mem_rsp_rdata  in  CORE_XLEN  full word
- mem_rsp_err  in  1  bus error
- cmp_valid  out  1  one-cycle completion pulse
- cmp_rd_wen  out  1  successful load
- cmp_rd  out  5  latched rd
- cmp_data  out  CORE_XLEN  aligned load data, or faulting byte address when cmp_exc=1
- cmp_exc  out  1  exception
- cmp_cause  out  2  01 load misaligned, 10 store misaligned, 11 access fault
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RSP, DRAIN.
- IDLE:
  - Accept when req_valid & req_ready. Latch wen, inst, addr, wdata, rd.
  - Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
  - Misaligned: no bus access; cmp with exc and cause 01 or 10; stay IDLE.
  - Aligned: go to REQ.
- REQ:
  - mem_req_valid=1. Address, data and mask are held stable until mem_req_ready.
  - On mem_req_ready: go to RSP and clear the timeout counter.
  - flush before the handshake: go to IDLE, no cmp.
- RSP:
  - On mem_rsp_valid with err: cmp with exc and cause 11.
  - On mem_rsp_valid for a load: cmp with cmp_rd_wen=1. cmp_data is selected by latched addr[1:0] plus the sign/zero rule from the inst bits.
  - On mem_rsp_valid for a store: cmp with cmp_rd_wen=0 and cmp_exc=0.
  - In all three cases go to IDLE.
  - Counter reaching RSP_TIMEOUT without a response: cmp with cause 11, go to IDLE.
  - flush: go to DRAIN, because the bus is committed.
- DRAIN: wait for mem_rsp_valid or the timeout, then go to IDLE with no cmp.
- mem_rsp_valid in IDLE or REQ is stray and ignored.

## Timing
- Reset values: state IDLE; all cmp_*, mem_req_* and busy are 0; counter 0; req_ready=1.
- Aligned access:
  - Accept at cycle 0; mem_req_valid from cycle 1.
  - Handshake at cycle h puts the controller in RSP at h+1.
  - Response at cycle k gives cmp_valid at k+1, with req_ready=1 at k+1. Back-to-back: next accept at k+1.
- Misaligned: accept at cycle 0, cmp_valid at cycle 1, req_ready stays high so a new accept is possible at cycle 1.
- flush has priority over the same-cycle req_valid, mem_req_ready and mem_rsp_valid.
- The earliest legal response is the cycle after the request handshake.
- cmp_* outputs are registered and valid only with cmp_valid; cmp_valid is never high two consecutive cycles for one request.
- Reset asserted mid-operation: return to IDLE immediately; an outstanding response is ignored.

## Structure
- Shared defines header holds:
  - CORE_XLEN, CORE_LSU_INST_WIDTH, CORE_LSU_WMASK_WIDTH
  - CORE_LSU_INST_B/H/W/LU bit indices
  - new cause codes CORE_LSU_CAUSE_LMA, CORE_LSU_CAUSE_SMA, CORE_LSU_CAUSE_AF
  - state encodings
- Sub-module: the existing core_ex_lsu_align, driven from the latched request. It supplies wmask, shifted write data and aligned read data.
- The controller computes misalignment for both loads and stores itself.

## Test plan
- LW at 0x100, ready at cycle 1, rsp rdata=0x8899AABB at cycle 3:
  - mem_req_addr=0x100 and wmask=0000 at cycle 1.
  - cycle 4: cmp_valid, rd_wen=1, data=0x8899AABB.
- LB at 0x103 with rdata=0x80xxxxxx gives data=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at 0x202, wdata=0x1234:
  - wmask=1100, mem_req_wdata=0x12340000, addr 0x200.
  - cmp with rd_wen=0 and exc=0.
- Misaligned and fault cases:
  - LW at 0x101: no mem_req_valid; cmp_exc=1, cause=01, data=0x101 at cycle 1.
  - SH at 0x203: no mem_req_valid; cmp_exc=1, cause=10.
  - Response with mem_rsp_err=1: cause=11.
- Timeout with RSP_TIMEOUT=4 and no response: cmp_exc=1, cause=11 exactly 4 cycles after entering RSP.
- Flush cases:
  - Flush in REQ: no cmp, IDLE next cycle.
  - Flush in RSP: the response is swallowed with no cmp; req_ready returns the cycle after the response.
  - Reset mid-RSP: all outputs 0.
